cla_multicycle_adder: RTL and testbench

Parametrised, multi-cycle carry-lookahead adder/subtractor. It processes a WIDTH-bit operand pair one SLICE-bit lookahead group per clock and ripples the group carry through a register between cycles. This trades latency for a small, fixed-depth lookahead slice. It sits next to the flat 8-bit lookahead carry unit as its wide, sequential successor, and adds subtraction, a start/busy/done handshake and signed overflow.

---
 rtl/cla_multicycle_adder_if.sv | 27 ++
 rtl/cla_multicycle_adder.sv | 185 ++++++++++++++++++
 tb/tb_cla_multicycle_adder.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_multicycle_adder_if.sv
// Handshake and operand/result bundle for cla_multicycle_adder.
// The master drives the request side (start, sub, cin, a, b); the slave
// (the adder) returns busy/done and the registered result.
interface cla_multicycle_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/cla_multicycle_adder.sv
// Multi-cycle carry-lookahead adder/subtractor.
// One SLICE-bit lookahead group is resolved per clock; the group carry is
// held in carry_r between cycles. Partial sums collect in acc_r and are
// only copied to the visible sum on the completion edge, so intermediate
// slices never appear on the outputs.
module cla_multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    cla_multicycle_adder_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;

    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  acc_r;
    logic              carry_r;
    logic [IDXW-1:0]   idx_r;

    logic              busy_r;
    logic              done_r;
    logic [WIDTH-1:0]  sum_r;
    logic              cout_r;
    logic              ovf_r;

    logic              accept_s;
    logic              last_s;
    logic [31:0]       base_s;
    logic [SLICE-1:0]  a_slice_s;
    logic [SLICE-1:0]  b_slice_s;
    logic [SLICE-1:0]  p_s;
    logic [SLICE-1:0]  g_s;
    logic [SLICE-1:0]  c_s;
    logic [SLICE-1:0]  gen_c_s;
    logic              group_p_s;
    logic              group_g_s;
    logic              slice_cout_s;
    logic [SLICE-1:0]  slice_sum_s;
    logic [WIDTH-1:0]  result_s;

    // Flattened lookahead: every carry is a sum of products of the generate
    // and propagate terms plus the incoming carry, with no ripple chain.
    function automatic logic [SLICE-1:0] la_carries(
        input logic [SLICE-1:0] p,
        input logic [SLICE-1:0] g,
        input logic             c_in
    );
        logic [SLICE-1:0] c;
        logic             term;
        for (int i = 0; i < SLICE; i++) begin
            c[i] = g[i];
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i] = c[i] | term;
            end
            term = c_in;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            c[i] = c[i] | term;
        end
        return c;
    endfunction

    assign accept_s     = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_s       = (idx_r == IDXW'(NSLICE - 1));
    assign base_s       = 32'(idx_r) * 32'(SLICE);

    assign a_slice_s    = a_r[base_s +: SLICE];
    assign b_slice_s    = b_r[base_s +: SLICE];
    assign p_s          = a_slice_s ^ b_slice_s;
    assign g_s          = a_slice_s & b_slice_s;
    assign c_s          = la_carries(p_s, g_s, carry_r);
    assign gen_c_s      = la_carries(p_s, g_s, 1'b0);
    assign group_p_s    = &p_s;
    assign group_g_s    = gen_c_s[SLICE-1];
    assign slice_cout_s = group_g_s | (group_p_s & carry_r);
    assign slice_sum_s  = p_s ^ {c_s[SLICE-2:0], carry_r};

    // Accumulator with the current slice's sum bits merged in
    always_comb begin
        result_s = acc_r;
        result_s[base_s +: SLICE] = slice_sum_s;
    end

    // Next-state logic: accept in IDLE/DONE, finish on the last slice
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand capture on accept, then one slice per cycle into the accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDXW{1'b0}};
        end else if (accept_s) begin
            a_r     <= bus.a;
            b_r     <= bus.b ^ {WIDTH{bus.sub}};
            carry_r <= bus.sub ? ~bus.cin : bus.cin;
            idx_r   <= {IDXW{1'b0}};
        end else if (state_r == ST_BUSY) begin
            acc_r   <= result_s;
            carry_r <= slice_cout_s;
            idx_r   <= last_s ? {IDXW{1'b0}} : (idx_r + IDXW'(1));
        end
    end

    // Registered handshake flags and result, updated only on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == ST_BUSY);
            done_r <= (state_nx_s == ST_DONE);
            if ((state_r == ST_BUSY) && last_s) begin
                sum_r  <= result_s;
                cout_r <= slice_cout_s;
                ovf_r  <= c_s[SLICE-2] ^ slice_cout_s;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum      = sum_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_cla_multicycle_adder.sv
// Bench for cla_multicycle_adder: three instances (SLICE = 4, 8, 32) with a
// per-instance scoreboard of expected result and expected done cycle.
module tb_cla_multicycle_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_multicycle_adder_if #(.WIDTH(32)) i4 ();
    cla_multicycle_adder_if #(.WIDTH(32)) i8 ();
    cla_multicycle_adder_if #(.WIDTH(32)) i32 ();

    cla_multicycle_adder #(.WIDTH(32), .SLICE(4))  u4  (.clk(clk), .rst(rst), .bus(i4));
    cla_multicycle_adder #(.WIDTH(32), .SLICE(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
    cla_multicycle_adder #(.WIDTH(32), .SLICE(32)) u32 (.clk(clk), .rst(rst), .bus(i32));

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        q4[$], q8[$], q32[$];
    exp_t        e4, e8, e32;
    logic [31:0] last8 = 32'd0;

    // Golden model: wide add with explicit carry; done expected lat cycles after accept
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic cin, input int lat);
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] full;
        logic        c0;
        logic        cmsb;
        bb   = sub ? ~b : b;
        c0   = sub ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, c0};
        cmsb = a[31] ^ bb[31] ^ full[31];
        e.sum  = full[31:0];
        e.cout = full[32];
        e.ovf  = cmsb ^ full[32];
        e.cyc  = cyc + 1 + lat;
        return e;
    endfunction

    // Scoreboard for SLICE=8, plus sum stability between completions
    always @(negedge clk) begin
        if (rst) begin
            last8 = 32'd0;
        end else if (i8.done) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL done8_unexpected sum=%h at cyc %0d", i8.sum, cyc);
            end else begin
                e8 = q8.pop_front();
                if (i8.sum !== e8.sum || i8.cout !== e8.cout || i8.overflow !== e8.ovf || cyc != e8.cyc) begin
                    errors++;
                    $display("FAIL result8 got sum=%h cout=%b ovf=%b cyc=%0d want sum=%h cout=%b ovf=%b cyc=%0d",
                             i8.sum, i8.cout, i8.overflow, cyc, e8.sum, e8.cout, e8.ovf, e8.cyc);
                end
            end
            last8 = i8.sum;
        end else begin
            checks++;
            if (i8.sum !== last8) begin
                errors++;
                $display("FAIL sum8_stable got %h want %h at cyc %0d", i8.sum, last8, cyc);
            end
        end
    end

    // Scoreboard for SLICE=4
    always @(negedge clk) begin
        if (!rst && i4.done) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL done4_unexpected sum=%h at cyc %0d", i4.sum, cyc);
            end else begin
                e4 = q4.pop_front();
                if (i4.sum !== e4.sum || i4.cout !== e4.cout || i4.overflow !== e4.ovf || cyc != e4.cyc) begin
                    errors++;
                    $display("FAIL result4 got sum=%h cout=%b ovf=%b cyc=%0d want sum=%h cout=%b ovf=%b cyc=%0d",
                             i4.sum, i4.cout, i4.overflow, cyc, e4.sum, e4.cout, e4.ovf, e4.cyc);
                end
            end
        end
    end

    // Scoreboard for SLICE=32
    always @(negedge clk) begin
        if (!rst && i32.done) begin
            checks++;
            if (q32.size() == 0) begin
                errors++;
                $display("FAIL done32_unexpected sum=%h at cyc %0d", i32.sum, cyc);
            end else begin
                e32 = q32.pop_front();
                if (i32.sum !== e32.sum || i32.cout !== e32.cout || i32.overflow !== e32.ovf || cyc != e32.cyc) begin
                    errors++;
                    $display("FAIL result32 got sum=%h cout=%b ovf=%b cyc=%0d want sum=%h cout=%b ovf=%b cyc=%0d",
                             i32.sum, i32.cout, i32.overflow, cyc, e32.sum, e32.cout, e32.ovf, e32.cyc);
                end
            end
        end
    end

    // Issue one op on the SLICE=8 instance at a negedge and wait for done
    task automatic run8(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin,
                        output logic [31:0] s, output logic co, output logic ov, output int bc);
        bit got;
        i8.a = a; i8.b = b; i8.sub = sub; i8.cin = cin; i8.start = 1'b1;
        q8.push_back(model(a, b, sub, cin, 4));
        bc  = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            i8.start = 1'b0;
            i8.a = $urandom; i8.b = $urandom; i8.sub = 1'($urandom); i8.cin = 1'($urandom);
            if (i8.done) begin
                got = 1'b1;
                break;
            end
            if (i8.busy) bc++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout8 got no done want done within 20 cycles");
        end
        s = i8.sum; co = i8.cout; ov = i8.overflow;
    endtask

    task automatic test_reset();
        i4.start = 1'b0;  i4.sub = 1'b0;  i4.cin = 1'b0;  i4.a = 32'd0;  i4.b = 32'd0;
        i8.start = 1'b0;  i8.sub = 1'b0;  i8.cin = 1'b0;  i8.a = 32'd0;  i8.b = 32'd0;
        i32.start = 1'b0; i32.sub = 1'b0; i32.cin = 1'b0; i32.a = 32'd0; i32.b = 32'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({i4.busy, i4.done, i4.cout, i4.overflow, i8.busy, i8.done, i8.cout, i8.overflow,
             i32.busy, i32.done, i32.cout, i32.overflow} !== 12'd0 ||
            i4.sum !== 32'd0 || i8.sum !== 32'd0 || i32.sum !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got sums %h %h %h flags nonzero want all 0", i4.sum, i8.sum, i32.sum);
        end
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_carry_chain();
        logic [31:0] s; logic co, ov; int bc;
        run8(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, co, ov, bc);
        checks++;
        if (s !== 32'h0 || co !== 1'b1 || ov !== 1'b0 || bc != 4) begin
            errors++;
            $display("FAIL carry_chain got sum=%h cout=%b ovf=%b busy=%0d want 00000000 1 0 4", s, co, ov, bc);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] s; logic co, ov; int bc;
        run8(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, co, ov, bc);
        checks++;
        if (s !== 32'h8000_0000 || co !== 1'b0 || ov !== 1'b1) begin
            errors++;
            $display("FAIL signed_overflow got sum=%h cout=%b ovf=%b want 80000000 0 1", s, co, ov);
        end
    endtask

    task automatic test_subtract();
        logic [31:0] s; logic co, ov; int bc;
        run8(32'd5, 32'd7, 1'b1, 1'b0, s, co, ov, bc);
        checks++;
        if (s !== 32'hFFFF_FFFE || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL sub_5_7 got sum=%h cout=%b ovf=%b want fffffffe 0 0", s, co, ov);
        end
        run8(32'h8000_0000, 32'd1, 1'b1, 1'b0, s, co, ov, bc);
        checks++;
        if (s !== 32'h7FFF_FFFF || co !== 1'b1 || ov !== 1'b1) begin
            errors++;
            $display("FAIL sub_min_1 got sum=%h cout=%b ovf=%b want 7fffffff 1 1", s, co, ov);
        end
    endtask

    task automatic test_start_while_busy();
        bit got;
        i8.a = 32'h1234_5678; i8.b = 32'h1111_1111; i8.sub = 1'b0; i8.cin = 1'b0; i8.start = 1'b1;
        q8.push_back(model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 4));
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i < 2) begin
                i8.start = 1'b1; i8.a = 32'hFFFF_FFFF; i8.b = 32'hFFFF_FFFF; i8.sub = 1'b1; i8.cin = 1'b1;
            end else begin
                i8.start = 1'b0;
            end
            if (i8.done) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || i8.sum !== 32'h2345_6789) begin
            errors++;
            $display("FAIL busy_start_ignored got done=%b sum=%h want 1 23456789", got, i8.sum);
        end
        i8.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (i8.done !== 1'b0 || i8.busy !== 1'b0) begin
                errors++;
                $display("FAIL no_extra_op got done=%b busy=%b want 0 0", i8.done, i8.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] s; logic co, ov; int bc;
        bit got;
        run8(32'd100, 32'd23, 1'b0, 1'b0, s, co, ov, bc);
        i8.a = 32'hFFFF_0000; i8.b = 32'h0000_FFFF; i8.sub = 1'b0; i8.cin = 1'b1; i8.start = 1'b1;
        q8.push_back(model(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b1, 4));
        @(negedge clk);
        i8.start = 1'b0;
        checks++;
        if (i8.busy !== 1'b1 || i8.done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_gap got busy=%b done=%b want 1 0", i8.busy, i8.done);
        end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i8.done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got || i8.sum !== 32'h0 || i8.cout !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_result got done=%b sum=%h cout=%b want 1 00000000 1", got, i8.sum, i8.cout);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] s; logic co, ov; int bc;
        run8(32'd1, 32'd1, 1'b0, 1'b0, s, co, ov, bc);
        i8.a = 32'hAAAA_AAAA; i8.b = 32'h1111_1111; i8.sub = 1'b0; i8.cin = 1'b0; i8.start = 1'b1;
        @(posedge clk);
        #1 i8.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (i8.busy !== 1'b0 || i8.done !== 1'b0 || i8.sum !== 32'h0 || i8.cout !== 1'b0 || i8.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     i8.busy, i8.done, i8.sum, i8.cout, i8.overflow);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        run8(32'd3, 32'd4, 1'b0, 1'b0, s, co, ov, bc);
        checks++;
        if (s !== 32'd7 || bc != 4) begin
            errors++;
            $display("FAIL after_reset_op got sum=%h busy=%0d want 00000007 4", s, bc);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] a, b;
        logic        sub, cin;
        bit          got;
        for (int n = 0; n < 400; n++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
            if (n == 0) begin a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0; cin = 1'b0; end
            if (n == 1) begin a = 32'h8000_0000; b = 32'h8000_0000; sub = 1'b0; cin = 1'b1; end
            if (n == 2) begin a = 32'h0;         b = 32'h0;         sub = 1'b1; cin = 1'b1; end
            i4.a = a;  i4.b = b;  i4.sub = sub;  i4.cin = cin;  i4.start = 1'b1;
            i8.a = a;  i8.b = b;  i8.sub = sub;  i8.cin = cin;  i8.start = 1'b1;
            i32.a = a; i32.b = b; i32.sub = sub; i32.cin = cin; i32.start = 1'b1;
            q4.push_back(model(a, b, sub, cin, 8));
            q8.push_back(model(a, b, sub, cin, 4));
            q32.push_back(model(a, b, sub, cin, 1));
            got = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                i4.start = 1'b0; i8.start = 1'b0; i32.start = 1'b0;
                i4.a = $urandom; i8.b = $urandom; i32.a = $urandom;
                if (i4.done) begin
                    got = 1'b1;
                    break;
                end
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL timeout_sweep got no done from SLICE=4 want done within 30 cycles, op %0d", n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_overflow();
        test_subtract();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep();
        repeat (3) @(negedge clk);
        checks++;
        if (q4.size() != 0 || q8.size() != 0 || q32.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d/%0d/%0d pending want 0/0/0", q4.size(), q8.size(), q32.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
